// File: rtl/lag_measure_ctrl_if.sv
// rtl/lag_measure_ctrl_if.sv - start/sensor/counter/result bundle for lag_measure_ctrl
interface lag_measure_ctrl_if;
  logic        start;
  logic        sensor_in;
  logic [23:0] cnt_bcd;
  logic        cnt_trigger;
  logic        cnt_reset;
  logic        flash_out;
  logic        busy;
  logic [23:0] result_bcd;
  logic        result_valid;
  logic        result_timeout;
  logic        result_ack;

  modport master (
    output start, sensor_in, cnt_bcd, result_ack,
    input  cnt_trigger, cnt_reset, flash_out, busy,
    input  result_bcd, result_valid, result_timeout
  );

  modport slave (
    input  start, sensor_in, cnt_bcd, result_ack,
    output cnt_trigger, cnt_reset, flash_out, busy,
    output result_bcd, result_valid, result_timeout
  );
endinterface

// File: rtl/lag_measure_ctrl.sv
// rtl/lag_measure_ctrl.sv - sequences one flash-to-sensor latency measurement on an external BCD counter
module lag_measure_ctrl #(
  parameter int TICK_DIV      = 2700,
  parameter int TIMEOUT_TICKS = 5000,
  parameter int HOLDOFF_TICKS = 1000
) (
  input logic              clk,
  input logic              reset,
  lag_measure_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("lag_measure_ctrl: TICK_DIV must be >= 2");
  end
  if (TIMEOUT_TICKS > 999999) begin : g_bad_timeout
    $error("lag_measure_ctrl: TIMEOUT_TICKS must be <= 999999");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COUNT, S_SETTLE, S_CAPTURE, S_HOLDOFF
  } state_t;

  state_t        state_q, state_d;
  logic          clr_cnt_q, clr_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [19:0]   tick_q, tick_d;
  logic          timeout_flag_q, timeout_flag_d;
  logic          cnt_trigger_q, cnt_trigger_d;
  logic          cnt_reset_q, cnt_reset_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          sync_prev_q, sync_prev_d;
  logic [23:0]   result_bcd_q, result_bcd_d;
  logic          result_valid_q, result_valid_d;
  logic          result_timeout_q, result_timeout_d;

  logic          wrap;
  logic [19:0]   tick_inc;
  logic          sensor_edge;

  always_comb begin
    state_d          = state_q;
    clr_cnt_d        = clr_cnt_q;
    presc_d          = presc_q;
    tick_d           = tick_q;
    timeout_flag_d   = timeout_flag_q;
    cnt_trigger_d    = 1'b0;
    sync1_d          = bus.sensor_in;
    sync2_d          = sync1_q;
    sync_prev_d      = sync2_q;
    result_bcd_d     = result_bcd_q;
    result_valid_d   = result_valid_q;
    result_timeout_d = result_timeout_q;

    wrap        = (presc_q == PW'(TICK_DIV - 1));
    tick_inc    = tick_q + 20'd1;
    sensor_edge = sync2_q & ~sync_prev_q;

    if (bus.result_ack) begin
      result_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d          = S_CLEAR;
          clr_cnt_d        = 1'b0;
          result_valid_d   = 1'b0;
          result_timeout_d = 1'b0;
        end
      end
      S_CLEAR: begin
        presc_d        = '0;
        tick_d         = '0;
        timeout_flag_d = 1'b0;
        clr_cnt_d      = 1'b1;
        if (clr_cnt_q) begin
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        presc_d = wrap ? '0 : presc_q + PW'(1);
        if (wrap) begin
          cnt_trigger_d = 1'b1;
          tick_d        = tick_inc;
        end
        // A sensor edge beats a timeout landing in the same cycle.
        if (sensor_edge) begin
          state_d = S_SETTLE;
        end else if (wrap && tick_inc == 20'(TIMEOUT_TICKS)) begin
          state_d        = S_SETTLE;
          timeout_flag_d = 1'b1;
        end
      end
      S_SETTLE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        result_bcd_d     = bus.cnt_bcd;
        result_timeout_d = timeout_flag_q;
        result_valid_d   = 1'b1;
        presc_d          = '0;
        tick_d           = '0;
        state_d          = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        presc_d = wrap ? '0 : presc_q + PW'(1);
        if (wrap) begin
          tick_d = tick_inc;
          if (tick_inc == 20'(HOLDOFF_TICKS)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cnt_reset_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      clr_cnt_q        <= 1'b0;
      presc_q          <= '0;
      tick_q           <= '0;
      timeout_flag_q   <= 1'b0;
      cnt_trigger_q    <= 1'b0;
      cnt_reset_q      <= 1'b1;
      sync1_q          <= 1'b0;
      sync2_q          <= 1'b0;
      sync_prev_q      <= 1'b0;
      result_bcd_q     <= '0;
      result_valid_q   <= 1'b0;
      result_timeout_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      clr_cnt_q        <= clr_cnt_d;
      presc_q          <= presc_d;
      tick_q           <= tick_d;
      timeout_flag_q   <= timeout_flag_d;
      cnt_trigger_q    <= cnt_trigger_d;
      cnt_reset_q      <= cnt_reset_d;
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      sync_prev_q      <= sync_prev_d;
      result_bcd_q     <= result_bcd_d;
      result_valid_q   <= result_valid_d;
      result_timeout_q <= result_timeout_d;
    end
  end

  assign bus.cnt_trigger    = cnt_trigger_q;
  assign bus.cnt_reset      = cnt_reset_q;
  assign bus.flash_out      = (state_q == S_COUNT) || (state_q == S_SETTLE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.result_bcd     = result_bcd_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_timeout = result_timeout_q;

endmodule

// File: tb/tb_lag_measure_ctrl.sv
// tb/tb_lag_measure_ctrl.sv - directed scoreboard bench for lag_measure_ctrl with a behavioural BCD counter
module tb_lag_measure_ctrl;

  logic clk;
  logic reset;

  lag_measure_ctrl_if bus ();

  lag_measure_ctrl #(
    .TICK_DIV      (4),
    .TIMEOUT_TICKS (20),
    .HOLDOFF_TICKS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [23:0] bcd_q = '0;
  int          trig_total = 0;

  always @(posedge clk) begin
    if (bus.cnt_reset === 1'b1) bcd_q <= '0;
    else if (bus.cnt_trigger === 1'b1) bcd_q <= bcd_inc(bcd_q);
    if (bus.cnt_trigger === 1'b1) trig_total <= trig_total + 1;
  end
  assign bus.cnt_bcd = bcd_q;

  typedef struct {
    logic [23:0] bcd;
    logic        to;
  } exp_t;
  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_trig(input int n, input string tag);
    int seen = 0;
    int b    = 0;
    while (seen < n && b < 1000) begin
      @(negedge clk);
      b++;
      if (bus.cnt_trigger === 1'b1) seen++;
    end
    if (seen < n) check(tag, seen, n);
  endtask

  // mode 1 toggles the sensor during holdoff, mode 2 pulses start during holdoff
  task automatic finish_meas(input string tag, input int base, input int exp_trigs, input int mode);
    exp_t e;
    int   b = 0;
    int   busy_cycles = 0;
    int   hold;
    while (bus.result_valid !== 1'b1 && b < 1000) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_valid"}, bus.result_valid, 1'b1);
    e = sb.pop_front();
    check({tag, "_bcd"}, bus.result_bcd, e.bcd);
    check({tag, "_timeout"}, bus.result_timeout, e.to);
    check({tag, "_flash"}, bus.flash_out, 1'b0);
    check({tag, "_trigs"}, trig_total - base, exp_trigs);
    hold = trig_total;
    while (bus.busy === 1'b1 && busy_cycles < 1000) begin
      busy_cycles++;
      if (mode == 1 && busy_cycles == 2) bus.sensor_in = 1'b0;
      if (mode == 1 && busy_cycles == 6) bus.sensor_in = 1'b1;
      if (mode == 2 && busy_cycles == 5) bus.start = 1'b1;
      if (mode == 2 && busy_cycles == 6) bus.start = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_busy_cycles"}, busy_cycles, 12);
    check({tag, "_holdoff_trigs"}, trig_total - hold, 0);
    check({tag, "_bcd_after"}, bus.result_bcd, e.bcd);
    check({tag, "_timeout_after"}, bus.result_timeout, e.to);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.sensor_in  = 1'b0;
    bus.result_ack = 1'b0;
    cyc(3);

    check("rst_cnt_reset", bus.cnt_reset, 1'b1);
    check("rst_cnt_trigger", bus.cnt_trigger, 1'b0);
    check("rst_flash", bus.flash_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_valid", bus.result_valid, 1'b0);
    check("rst_timeout", bus.result_timeout, 1'b0);
    check("rst_bcd", bus.result_bcd, 24'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_cnt_reset", bus.cnt_reset, 1'b0);

    // normal measurement: sensor rises after the 7th trigger
    base = trig_total;
    sb.push_back('{24'h000007, 1'b0});
    pulse_start;
    check("norm_clear", bus.cnt_reset, 1'b1);
    wait_trig(7, "norm_wait");
    check("norm_flash", bus.flash_out, 1'b1);
    bus.sensor_in = 1'b1;
    finish_meas("norm", base, 7, 0);
    bus.sensor_in = 1'b0;
    cyc(4);

    // no sensor: timeout
    base = trig_total;
    sb.push_back('{24'h000020, 1'b1});
    pulse_start;
    finish_meas("nosens", base, 20, 0);

    // sensor already high: no edge, timeout; edge in holdoff ignored
    bus.sensor_in = 1'b1;
    cyc(4);
    base = trig_total;
    sb.push_back('{24'h000020, 1'b1});
    pulse_start;
    finish_meas("senshigh", base, 20, 1);
    check("senshigh_valid_after", bus.result_valid, 1'b1);
    bus.sensor_in = 1'b0;
    cyc(4);

    // ack clears valid next cycle; a second ack is harmless
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    check("ack_clear", bus.result_valid, 1'b0);
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    check("ack_idle", bus.result_valid, 1'b0);

    // start pulses during COUNT and HOLDOFF are ignored
    base = trig_total;
    sb.push_back('{24'h000020, 1'b1});
    pulse_start;
    cyc(10);
    pulse_start;
    cyc(20);
    pulse_start;
    finish_meas("ignstart", base, 20, 2);
    cyc(3);
    check("ignstart_idle", bus.busy, 1'b0);

    // new start clears flags, counter cleared by CLEAR, then reset mid-COUNT
    pulse_start;
    check("restart_valid", bus.result_valid, 1'b0);
    check("restart_timeout", bus.result_timeout, 1'b0);
    check("restart_clr1", bus.cnt_reset, 1'b1);
    @(negedge clk);
    check("restart_clr2", bus.cnt_reset, 1'b1);
    check("restart_cnt_zero", bus.cnt_bcd, 24'h0);
    @(negedge clk);
    check("restart_clr_end", bus.cnt_reset, 1'b0);
    wait_trig(5, "midrst_wait");
    reset = 1'b1;
    #1;
    check("midrst_flash", bus.flash_out, 1'b0);
    check("midrst_cnt_reset", bus.cnt_reset, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_valid", bus.result_valid, 1'b0);
    cyc(2);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_rel", bus.cnt_reset, 1'b0);

    // run after reset starts from zero
    base = trig_total;
    sb.push_back('{24'h000003, 1'b0});
    pulse_start;
    wait_trig(3, "postrst_wait");
    bus.sensor_in = 1'b1;
    finish_meas("postrst", base, 3, 0);
    bus.sensor_in = 1'b0;
    cyc(4);

    // edge lands on the 20th tick: edge wins, trigger still issued
    base = trig_total;
    sb.push_back('{24'h000020, 1'b0});
    pulse_start;
    wait_trig(19, "coinc_wait");
    @(negedge clk);
    bus.sensor_in = 1'b1;
    finish_meas("coinc", base, 20, 0);
    bus.sensor_in = 1'b0;
    cyc(2);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
